// File: rtl/mult_seq_pkg.sv
// +----------------------------------------------------------------------+
// | mult_seq_pkg : shared types and helpers for the sequential multiplier |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

package mult_seq_pkg;

   localparam int MAX_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_SIGN = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Input must already be sign-extended to MAX_W; the result of a W-bit
   // operand always fits in W unsigned bits, including -2^(W-1).
   function automatic logic [MAX_W-1:0] abs_mag(input logic [MAX_W-1:0] v);
      return v[MAX_W-1] ? (~v + MAX_W'(1)) : v;
   endfunction

   function automatic bit width_ok(input int w);
      return ((w % 2) == 0) && (w >= 4) && (w <= MAX_W);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mult2x2.sv
// +----------------------------------------------------------------------+
// | mult2x2  : combinational 2-bit x 2-bit unsigned digit multiplier      |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module mult2x2 (
   input  logic [1:0] a_i,
   input  logic [1:0] b_i,
   output logic [3:0] p_o
);

   assign p_o = {2'b00, a_i} * {2'b00, b_i};

endmodule

`default_nettype wire

// File: rtl/mult_seq_nxn.sv
// +----------------------------------------------------------------------+
// | mult_seq_nxn : sequential NxN multiplier, one 2x2 digit product per   |
// |                clock, optional two's-complement mode                  |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

module mult_seq_nxn
   import mult_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset_a_n,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     dataa,
   input  logic [WIDTH-1:0]     datab,
   output logic                 busy,
   output logic                 done_flag,
   output logic [2*WIDTH-1:0]   product_out
);

   localparam int D  = WIDTH / 2;
   localparam int CW = (D > 1) ? $clog2(D) : 1;
   localparam int PW = 2 * WIDTH;

   generate
      if (!width_ok(WIDTH)) begin : g_width_check
         $error("mult_seq_nxn: WIDTH must be even and within 4..16");
      end
   endgenerate

   state_e            state_q;
   logic [WIDTH-1:0]  mag_a_q, mag_b_q;
   logic [WIDTH-1:0]  mag_a_d, mag_b_d;
   logic              neg_q, neg_d;
   logic              busy_q, done_q;
   logic [CW-1:0]     i_q, j_q;
   logic [PW-1:0]     acc_q, acc_d, prod_q;

   logic [MAX_W-1:0]  a_abs, b_abs;
   logic              unused_abs;
   logic [WIDTH-1:0]  a_sh, b_sh;
   logic [3:0]        digit_prod;
   logic [CW:0]       digit_pos;
   logic              last_step;

   assign a_abs      = abs_mag(MAX_W'($signed(dataa)));
   assign b_abs      = abs_mag(MAX_W'($signed(datab)));
   assign unused_abs = ^{a_abs, b_abs};
   assign mag_a_d    = signed_mode ? a_abs[WIDTH-1:0] : dataa;
   assign mag_b_d    = signed_mode ? b_abs[WIDTH-1:0] : datab;
   assign neg_d      = signed_mode & (dataa[WIDTH-1] ^ datab[WIDTH-1]);

   assign a_sh       = mag_a_q >> {i_q, 1'b0};
   assign b_sh       = mag_b_q >> {j_q, 1'b0};
   assign digit_pos  = {1'b0, i_q} + {1'b0, j_q};
   assign acc_d      = acc_q + (PW'(digit_prod) << {digit_pos, 1'b0});
   assign last_step  = (i_q == CW'(D - 1)) && (j_q == CW'(D - 1));

   mult2x2 u_digit_mult (
      .a_i (a_sh[1:0]),
      .b_i (b_sh[1:0]),
      .p_o (digit_prod)
   );

   always_ff @(posedge clk or negedge reset_a_n) begin
      if (!reset_a_n) begin
         state_q <= ST_IDLE;
         mag_a_q <= '0;
         mag_b_q <= '0;
         neg_q   <= 1'b0;
         i_q     <= '0;
         j_q     <= '0;
         acc_q   <= '0;
         prod_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  mag_a_q <= mag_a_d;
                  mag_b_q <= mag_b_d;
                  neg_q   <= neg_d;
                  acc_q   <= '0;
                  i_q     <= '0;
                  j_q     <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_CALC;
               end
            end
            ST_CALC: begin
               acc_q <= acc_d;
               // j is the inner digit loop, i advances when j wraps
               if (j_q == CW'(D - 1)) begin
                  j_q <= '0;
                  i_q <= i_q + CW'(1);
               end else begin
                  j_q <= j_q + CW'(1);
               end
               if (last_step) begin
                  state_q <= ST_SIGN;
               end
            end
            ST_SIGN: begin
               prod_q  <= neg_q ? (~acc_q + PW'(1)) : acc_q;
               done_q  <= 1'b1;
               state_q <= ST_DONE;
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign done_flag   = done_q;
   assign product_out = prod_q;

endmodule

`default_nettype wire
